// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Receive end of the shift-register serial link. Rebuilds parallel words from
// a serial bit stream framed as: start(1), WIDTH data bits LSB first,
// optional even-parity bit, stop(0). The idle line is low.
// The frame FSM state, bit counter, parity-error flag and shift register are
// held in three copies. They are majority-voted and rewritten every cycle, so
// a single upset is scrubbed within one clock. Completed words go to a
// first-word-fall-through FIFO with a valid/ready output.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   serial_in    in   serial line bit
//   serial_valid in   serial_in is sampled only when 1
//   data_out     out  FIFO head word (0 while empty)
//   data_valid   out  FIFO not empty
//   data_ready   in   consumer accepts data_out when data_valid & data_ready
//   parity_err   out  one-cycle pulse, frame dropped on parity mismatch
//   frame_err    out  one-cycle pulse, frame dropped on bad stop bit
//   overrun      out  one-cycle pulse, good frame dropped because FIFO full
//   tmr_mismatch out  one-cycle pulse, a redundant copy disagreed with vote
//   busy         out  voted FSM state is not IDLE
module serial_frame_rx #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int PARITY_EN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             tmr_mismatch,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    // Redundant word layout: {shreg, perr, bit_cnt, state}
    localparam int TW = 2 + CW + 1 + WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    // Even parity: any odd number of ones across data and parity bit is an error
    function automatic logic parity_mismatch(input logic [WIDTH-1:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Bitwise 2-of-3 majority
    function automatic logic [TW-1:0] vote3(input logic [TW-1:0] a,
                                            input logic [TW-1:0] b,
                                            input logic [TW-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [TW-1:0]    copy_a_q, copy_b_q, copy_c_q;
    logic [TW-1:0]    vote_s, tmr_d;
    state_e           state_v_s, state_d;
    logic [CW-1:0]    cnt_v_s, cnt_d;
    logic             perr_v_s, perr_d;
    logic [WIDTH-1:0] sh_v_s, sh_d;
    logic             push_s, pop_s, full_s;
    logic             perr_ev_s, ferr_ev_s, ovr_ev_s;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;

    assign vote_s    = vote3(copy_a_q, copy_b_q, copy_c_q);
    assign state_v_s = state_e'(vote_s[1:0]);
    assign cnt_v_s   = vote_s[2 +: CW];
    assign perr_v_s  = vote_s[2 + CW];
    assign sh_v_s    = vote_s[TW-1 -: WIDTH];

    assign data_valid = (count_q != '0);
    assign full_s     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign pop_s      = data_valid & data_ready;
    assign data_out   = data_valid ? mem_q[rd_ptr_q] : '0;
    assign busy       = (state_v_s != S_IDLE);

    // Frame FSM next state, computed from the voted copy
    always_comb begin
        state_d   = state_v_s;
        cnt_d     = cnt_v_s;
        perr_d    = perr_v_s;
        sh_d      = sh_v_s;
        push_s    = 1'b0;
        perr_ev_s = 1'b0;
        ferr_ev_s = 1'b0;
        ovr_ev_s  = 1'b0;
        if (serial_valid) begin
            case (state_v_s)
                S_IDLE: begin
                    if (serial_in) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    sh_d = {serial_in, sh_v_s[WIDTH-1:1]};
                    if (cnt_v_s == CW'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        cnt_d = cnt_v_s + 1'b1;
                    end
                end
                S_PARITY: begin
                    perr_d  = parity_mismatch(sh_v_s, serial_in);
                    state_d = S_STOP;
                end
                S_STOP: begin
                    // A high stop bit is a framing error, never a new start
                    state_d = S_IDLE;
                    if (serial_in) begin
                        ferr_ev_s = 1'b1;
                    end else if (perr_v_s) begin
                        perr_ev_s = 1'b1;
                    end else if (full_s && !pop_s) begin
                        ovr_ev_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_v_s;
        end
        tmr_d = {sh_d, perr_d, cnt_d, state_d};
    end

    // Redundant FSM registers (rewritten with the voted next value) and event flags
    always_ff @(posedge clk) begin
        if (rst) begin
            copy_a_q     <= '0;
            copy_b_q     <= '0;
            copy_c_q     <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            tmr_mismatch <= 1'b0;
        end else begin
            copy_a_q     <= tmr_d;
            copy_b_q     <= tmr_d;
            copy_c_q     <= tmr_d;
            parity_err   <= perr_ev_s;
            frame_err    <= ferr_ev_s;
            overrun      <= ovr_ev_s;
            tmr_mismatch <= |((copy_a_q ^ vote_s) | (copy_b_q ^ vote_s) | (copy_c_q ^ vote_s));
        end
    end

    // Output FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= sh_v_s;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_q <= count_q + 1'b1;
            end else if (!push_s && pop_s) begin
                count_q <= count_q - 1'b1;
            end else begin
                count_q <= count_q;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    localparam int WIDTH = 4;
    localparam int TW    = 2 + $clog2(WIDTH) + 1 + WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             serial_in;
    logic             serial_valid;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;
    logic             tmr_mismatch;
    logic             busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [TW-1:0] tmp_r;

    serial_frame_rx #(.WIDTH(4), .FIFO_DEPTH(2), .PARITY_EN(1)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
        .tmr_mismatch(tmr_mismatch), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive inputs at a falling edge, let one rising edge consume them,
    // return at the next falling edge with the registered results visible.
    task automatic tick(input logic b, input logic v);
        serial_in    = b;
        serial_valid = v;
        @(negedge clk);
    endtask

    // Start bit, four data bits LSB first, parity bit (stop bit sent by caller)
    task automatic send_body(input logic [3:0] d, input logic par);
        tick(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(d[i], 1'b1);
        tick(par, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; data_ready = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b0;
        total_cnt++;
        if ({data_valid, data_out, busy} !== 6'b0) $display("FAIL reset_out: got valid=%b data=%h busy=%b want 0/0/0", data_valid, data_out, busy);
        else pass_cnt++;
        total_cnt++;
        if ({parity_err, frame_err, overrun, tmr_mismatch} !== 4'b0) $display("FAIL reset_flags: got %b%b%b%b want 0000", parity_err, frame_err, overrun, tmr_mismatch);
        else pass_cnt++;
    endtask

    task automatic test_good_frame();
        data_ready = 1'b1;
        tick(1'b1, 1'b1);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL good_busy: got %b want 1", busy);
        else pass_cnt++;
        tick(1'b0, 1'b1); tick(1'b1, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        total_cnt++;
        if (data_valid !== 1'b0) $display("FAIL good_early_valid: got %b want 0", data_valid);
        else pass_cnt++;
        tick(1'b0, 1'b1);
        total_cnt++;
        if ({data_valid, data_out} !== {1'b1, 4'hA}) $display("FAIL good_data: got valid=%b data=%h want 1/a", data_valid, data_out);
        else pass_cnt++;
        total_cnt++;
        if ({parity_err, frame_err, overrun, busy} !== 4'b0) $display("FAIL good_flags: got %b%b%b busy=%b want 0000", parity_err, frame_err, overrun, busy);
        else pass_cnt++;
        tick(1'b0, 1'b0);
        total_cnt++;
        if (data_valid !== 1'b0) $display("FAIL good_pop: got valid=%b want 0", data_valid);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        data_ready = 1'b1;
        send_body(4'h3, 1'b1);
        tick(1'b0, 1'b1);
        total_cnt++;
        if ({parity_err, frame_err, data_valid} !== 3'b100) $display("FAIL perr_pulse: got perr=%b ferr=%b valid=%b want 1/0/0", parity_err, frame_err, data_valid);
        else pass_cnt++;
        tick(1'b0, 1'b0);
        total_cnt++;
        if ({parity_err, data_valid} !== 2'b00) $display("FAIL perr_once: got perr=%b valid=%b want 0/0", parity_err, data_valid);
        else pass_cnt++;
        send_body(4'h5, 1'b0);
        tick(1'b1, 1'b1);
        total_cnt++;
        if ({frame_err, parity_err, data_valid, busy} !== 4'b1000) $display("FAIL ferr_pulse: got ferr=%b perr=%b valid=%b busy=%b want 1/0/0/0", frame_err, parity_err, data_valid, busy);
        else pass_cnt++;
        tick(1'b0, 1'b1);
        total_cnt++;
        if ({frame_err, busy, data_valid} !== 3'b000) $display("FAIL ferr_after: got ferr=%b busy=%b valid=%b want 0/0/0", frame_err, busy, data_valid);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        send_body(4'h1, 1'b1); tick(1'b0, 1'b1);
        total_cnt++;
        if ({data_valid, data_out} !== {1'b1, 4'h1}) $display("FAIL ovr_first: got valid=%b data=%h want 1/1", data_valid, data_out);
        else pass_cnt++;
        send_body(4'h2, 1'b1); tick(1'b0, 1'b1);
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL ovr_second: got %b want 0", overrun);
        else pass_cnt++;
        send_body(4'h4, 1'b1); tick(1'b0, 1'b1);
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL ovr_pulse: got %b want 1", overrun);
        else pass_cnt++;
        data_ready = 1'b1;
        total_cnt++;
        if (data_out !== 4'h1) $display("FAIL ovr_order0: got %h want 1", data_out);
        else pass_cnt++;
        tick(1'b0, 1'b0);
        total_cnt++;
        if ({overrun, data_valid, data_out} !== {1'b0, 1'b1, 4'h2}) $display("FAIL ovr_order1: got ovr=%b valid=%b data=%h want 0/1/2", overrun, data_valid, data_out);
        else pass_cnt++;
        tick(1'b0, 1'b0);
        total_cnt++;
        if (data_valid !== 1'b0) $display("FAIL ovr_drain: got valid=%b want 0", data_valid);
        else pass_cnt++;
        // Full FIFO with a pop on the same cycle as the push
        data_ready = 1'b0;
        send_body(4'h1, 1'b1); tick(1'b0, 1'b1);
        send_body(4'h2, 1'b1); tick(1'b0, 1'b1);
        send_body(4'h4, 1'b1);
        data_ready = 1'b1;
        tick(1'b0, 1'b1);
        total_cnt++;
        if ({overrun, data_valid, data_out} !== {1'b0, 1'b1, 4'h2}) $display("FAIL pushpop_full: got ovr=%b valid=%b data=%h want 0/1/2", overrun, data_valid, data_out);
        else pass_cnt++;
        tick(1'b0, 1'b0);
        total_cnt++;
        if ({data_valid, data_out} !== {1'b1, 4'h4}) $display("FAIL pushpop_kept: got valid=%b data=%h want 1/4", data_valid, data_out);
        else pass_cnt++;
        tick(1'b0, 1'b0);
        total_cnt++;
        if (data_valid !== 1'b0) $display("FAIL pushpop_drain: got valid=%b want 0", data_valid);
        else pass_cnt++;
    endtask

    task automatic test_stalls();
        data_ready = 1'b1;
        // 0xC with idle-low bits before the start and serial_valid gaps
        tick(1'b0, 1'b1); tick(1'b1, 1'b0); tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0); tick(1'b0, 1'b1); tick(1'b1, 1'b0); tick(1'b0, 1'b1);
        tick(1'b1, 1'b1); tick(1'b0, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b0);
        tick(1'b0, 1'b1); tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        total_cnt++;
        if ({data_valid, data_out, parity_err, frame_err, overrun} !== {1'b1, 4'hC, 3'b000}) $display("FAIL stall_data: got valid=%b data=%h flags=%b%b%b want 1/c/000", data_valid, data_out, parity_err, frame_err, overrun);
        else pass_cnt++;
        tick(1'b0, 1'b0);
        // Reset in the middle of the data bits
        tick(1'b1, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1);
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        total_cnt++;
        if ({busy, data_valid, parity_err, frame_err, overrun} !== 5'b0) $display("FAIL midrst: got busy=%b valid=%b flags=%b%b%b want 0/0/000", busy, data_valid, parity_err, frame_err, overrun);
        else pass_cnt++;
        send_body(4'h6, 1'b0); tick(1'b0, 1'b1);
        total_cnt++;
        if ({data_valid, data_out, parity_err, frame_err} !== {1'b1, 4'h6, 2'b00}) $display("FAIL midrst_next: got valid=%b data=%h perr=%b ferr=%b want 1/6/0/0", data_valid, data_out, parity_err, frame_err);
        else pass_cnt++;
        tick(1'b0, 1'b0);
    endtask

    task automatic test_tmr();
        data_ready = 1'b1;
        tick(1'b1, 1'b1); tick(1'b1, 1'b1); tick(1'b0, 1'b1);
        total_cnt++;
        if (tmr_mismatch !== 1'b0) $display("FAIL tmr_quiet: got %b want 0", tmr_mismatch);
        else pass_cnt++;
        tmp_r = dut.copy_a_q;
        tmp_r[1:0] = 2'b11;
        force dut.copy_b_q = tmp_r;
        tick(1'b0, 1'b1);
        total_cnt++;
        if ({tmr_mismatch, busy} !== 2'b11) $display("FAIL tmr_pulse: got mismatch=%b busy=%b want 1/1", tmr_mismatch, busy);
        else pass_cnt++;
        tmp_r = dut.copy_a_q;
        force dut.copy_b_q = tmp_r;
        #1;
        release dut.copy_b_q;
        tick(1'b1, 1'b1);
        total_cnt++;
        if (tmr_mismatch !== 1'b0) $display("FAIL tmr_once: got %b want 0", tmr_mismatch);
        else pass_cnt++;
        tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        total_cnt++;
        if ({data_valid, data_out, parity_err, frame_err, tmr_mismatch} !== {1'b1, 4'h9, 3'b000}) $display("FAIL tmr_data: got valid=%b data=%h perr=%b ferr=%b mm=%b want 1/9/0/0/0", data_valid, data_out, parity_err, frame_err, tmr_mismatch);
        else pass_cnt++;
        tick(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; data_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_errors();
        test_overrun();
        test_stalls();
        test_tmr();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
